histogram_controller: RTL and testbench

Owns the histogram RAM and sequences its use across a frame: clears it, accumulates a 2^PIXEL_WIDTH-bin histogram from the decoded pixel stream, then on request rewrites it in place as a CDF while extracting CDF_min. It generates `histogram_generated`, `CDF_generated` and `CDF_min` for the filter block. It grants the RAM read port to the filter only when the RAM contents are stable.

---
 rtl/histogram_controller.sv | 212 +++++++++++++++++++++
 tb/tb_histogram_controller.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/histogram_controller.sv
// Histogram RAM sequencer: clears the RAM, accumulates a pixel histogram, then rewrites it
// in place as a CDF while capturing the first nonzero CDF value. Grants the read port to the filter when stable.
module histogram_controller #(
   parameter int PIXEL_WIDTH                 = 8,
   parameter int IMAGE_WIDTH                 = 320,
   parameter int IMAGE_HEIGHT                = 240,
   parameter int HISTOGRAM_RAM_ADDRESS_WIDTH = PIXEL_WIDTH,
   parameter int HISTOGRAM_RAM_DATA_WIDTH    = $clog2(IMAGE_WIDTH*IMAGE_HEIGHT)
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   start,
   input  logic                                   cdf_start,
   input  logic                                   pixel_valid,
   input  logic [PIXEL_WIDTH-1:0]                 pixel_data,
   output logic                                   pixel_ready,
   input  logic                                   filter_RAM_CE,
   input  logic [HISTOGRAM_RAM_ADDRESS_WIDTH-1:0] filter_RAM_address,
   output logic                                   histogram_RAM_CE,
   output logic                                   histogram_RAM_WE,
   output logic [HISTOGRAM_RAM_ADDRESS_WIDTH-1:0] histogram_RAM_address,
   output logic [HISTOGRAM_RAM_DATA_WIDTH-1:0]    histogram_RAM_write_data,
   input  logic [HISTOGRAM_RAM_DATA_WIDTH-1:0]    histogram_RAM_data,
   output logic                                   is_histogram_RAM_available,
   output logic                                   histogram_generated,
   output logic                                   CDF_generated,
   output logic [HISTOGRAM_RAM_DATA_WIDTH-1:0]    CDF_min,
   output logic                                   busy
);

   localparam int AW    = HISTOGRAM_RAM_ADDRESS_WIDTH;
   localparam int DW    = HISTOGRAM_RAM_DATA_WIDTH;
   localparam int TOTAL = IMAGE_WIDTH * IMAGE_HEIGHT;
   localparam int CW    = $clog2(TOTAL + 1);

   localparam logic [AW-1:0] LAST_BIN   = '1;
   localparam logic [CW-1:0] LAST_COUNT = CW'(TOTAL - 1);

   typedef enum logic [3:0] {
      IDLE,
      CLEAR,
      ACC_READ,
      ACC_WAIT,
      ACC_WRITE,
      HIST_DONE,
      CDF_READ,
      CDF_WRITE,
      CDF_DONE
   } state_t;

   state_t          state_q;
   logic [AW-1:0]   bin_q;
   logic [AW-1:0]   pix_q;
   logic [DW-1:0]   acc_q;
   logic [CW-1:0]   count_q;
   logic [DW-1:0]   sum_q;
   logic [DW-1:0]   sum_d;
   logic            min_found_q;
   logic            pixel_ready_q;
   logic            available_q;
   logic            hist_gen_q;
   logic            cdf_gen_q;
   logic            busy_q;
   logic [DW-1:0]   cdf_min_q;

   assign sum_d = sum_q + histogram_RAM_data;

   // RAM port is a decode of the current state so reads land in the cycle the FSM expects data.
   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      histogram_RAM_CE         = 1'b0;
      histogram_RAM_WE         = 1'b0;
      histogram_RAM_address    = '0;
      histogram_RAM_write_data = '0;
      case (state_q)
         CLEAR: begin
            histogram_RAM_CE      = 1'b1;
            histogram_RAM_WE      = 1'b1;
            histogram_RAM_address = bin_q;
         end
         ACC_READ: begin
            histogram_RAM_CE      = pixel_valid;
            histogram_RAM_address = AW'(pixel_data);
         end
         ACC_WRITE: begin
            histogram_RAM_CE         = 1'b1;
            histogram_RAM_WE         = 1'b1;
            histogram_RAM_address    = pix_q;
            histogram_RAM_write_data = acc_q;
         end
         HIST_DONE, CDF_DONE: begin
            histogram_RAM_CE      = filter_RAM_CE;
            histogram_RAM_address = filter_RAM_address;
         end
         CDF_READ: begin
            histogram_RAM_CE      = 1'b1;
            histogram_RAM_address = bin_q;
         end
         CDF_WRITE: begin
            histogram_RAM_CE         = 1'b1;
            histogram_RAM_WE         = 1'b1;
            histogram_RAM_address    = bin_q;
            histogram_RAM_write_data = sum_d;
         end
         default: ;
      endcase
   end

   // NOTE: the RAM contents are not reset here; the CLEAR pass zeroes every bin at the start of each frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         bin_q         <= '0;
         pix_q         <= '0;
         acc_q         <= '0;
         count_q       <= '0;
         sum_q         <= '0;
         min_found_q   <= 1'b0;
         pixel_ready_q <= 1'b0;
         available_q   <= 1'b0;
         hist_gen_q    <= 1'b0;
         cdf_gen_q     <= 1'b0;
         busy_q        <= 1'b0;
         cdf_min_q     <= '0;
      end else if (start) begin
         // NOTE: non-blocking assignments keep every register update in this block order-independent.
         state_q       <= CLEAR;
         bin_q         <= '0;
         count_q       <= '0;
         min_found_q   <= 1'b0;
         pixel_ready_q <= 1'b0;
         available_q   <= 1'b0;
         hist_gen_q    <= 1'b0;
         cdf_gen_q     <= 1'b0;
         busy_q        <= 1'b1;
         cdf_min_q     <= '0;
      end else begin
         case (state_q)
            CLEAR: begin
               if (bin_q == LAST_BIN) begin
                  state_q       <= ACC_READ;
                  count_q       <= '0;
                  pixel_ready_q <= 1'b1;
               end else begin
                  bin_q <= bin_q + AW'(1);
               end
            end
            ACC_READ: begin
               if (pixel_valid) begin
                  pix_q         <= AW'(pixel_data);
                  pixel_ready_q <= 1'b0;
                  state_q       <= ACC_WAIT;
               end
            end
            ACC_WAIT: begin
               acc_q   <= histogram_RAM_data + DW'(1);
               state_q <= ACC_WRITE;
            end
            ACC_WRITE: begin
               count_q <= count_q + CW'(1);
               if (count_q == LAST_COUNT) begin
                  state_q     <= HIST_DONE;
                  hist_gen_q  <= 1'b1;
                  available_q <= 1'b1;
                  busy_q      <= 1'b0;
               end else begin
                  state_q       <= ACC_READ;
                  pixel_ready_q <= 1'b1;
               end
            end
            HIST_DONE: begin
               if (cdf_start) begin
                  state_q     <= CDF_READ;
                  bin_q       <= '0;
                  sum_q       <= '0;
                  min_found_q <= 1'b0;
                  hist_gen_q  <= 1'b0;
                  available_q <= 1'b0;
                  busy_q      <= 1'b1;
               end
            end
            CDF_READ: state_q <= CDF_WRITE;
            CDF_WRITE: begin
               sum_q <= sum_d;
               if (!min_found_q && (sum_d != '0)) begin
                  cdf_min_q   <= sum_d;
                  min_found_q <= 1'b1;
               end
               if (bin_q == LAST_BIN) begin
                  state_q     <= CDF_DONE;
                  cdf_gen_q   <= 1'b1;
                  available_q <= 1'b1;
                  busy_q      <= 1'b0;
               end else begin
                  bin_q   <= bin_q + AW'(1);
                  state_q <= CDF_READ;
               end
            end
            IDLE, CDF_DONE: ;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign pixel_ready                = pixel_ready_q;
   assign is_histogram_RAM_available = available_q;
   assign histogram_generated        = hist_gen_q;
   assign CDF_generated              = cdf_gen_q;
   assign CDF_min                    = cdf_min_q;
   assign busy                       = busy_q;

endmodule

// File: tb/tb_histogram_controller.sv
// Directed bench for histogram_controller on a 4x4 frame, with a behavioural synchronous RAM.
module tb_histogram_controller;

   localparam int PW = 8;
   localparam int AW = 8;
   localparam int DW = 17;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          cdf_start = 1'b0;
   logic          pixel_valid = 1'b0;
   logic [PW-1:0] pixel_data = '0;
   logic          pixel_ready;
   logic          filter_ce = 1'b0;
   logic [AW-1:0] filter_addr = '0;
   logic          ram_ce;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wd;
   logic [DW-1:0] ram_rd = '0;
   logic          available;
   logic          hist_gen;
   logic          cdf_gen;
   logic [DW-1:0] cdf_min;
   logic          busy;

   logic [DW-1:0] mem [0:255];

   int vecs = 0;
   int errs = 0;

   always #5 clk = ~clk;

   histogram_controller #(
      .PIXEL_WIDTH(PW), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4),
      .HISTOGRAM_RAM_ADDRESS_WIDTH(AW), .HISTOGRAM_RAM_DATA_WIDTH(DW)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .cdf_start(cdf_start),
      .pixel_valid(pixel_valid), .pixel_data(pixel_data), .pixel_ready(pixel_ready),
      .filter_RAM_CE(filter_ce), .filter_RAM_address(filter_addr),
      .histogram_RAM_CE(ram_ce), .histogram_RAM_WE(ram_we),
      .histogram_RAM_address(ram_addr), .histogram_RAM_write_data(ram_wd),
      .histogram_RAM_data(ram_rd), .is_histogram_RAM_available(available),
      .histogram_generated(hist_gen), .CDF_generated(cdf_gen), .CDF_min(cdf_min),
      .busy(busy)
   );

   always @(posedge clk) begin
      if (ram_ce) begin
         if (ram_we) mem[ram_addr] <= ram_wd;
         else        ram_rd <= mem[ram_addr];
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc(1);
      start = 1'b0;
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (pixel_ready !== 1'b1 && n < 400) begin
         cyc(1);
         n++;
      end
      check(tag, pixel_ready, 1);
   endtask

   task automatic wait_hist(input string tag);
      int n = 0;
      while (hist_gen !== 1'b1 && n < 100) begin
         cyc(1);
         n++;
      end
      check(tag, hist_gen, 1);
   endtask

   task automatic run_cdf();
      cdf_start = 1'b1;
      cyc(1);
      cdf_start = 1'b0;
      cyc(511);
      check("cdf_last_write_we", ram_we, 1);
      check("cdf_last_write_addr", ram_addr, 255);
      check("cdf_gen_not_early", cdf_gen, 0);
      cyc(1);
      check("cdf_gen_rise", cdf_gen, 1);
   endtask

   initial begin
      int rdy;
      int hg;
      logic [PW-1:0] pix [16];

      // Reset state
      #3;
      check("rst_busy", busy, 0);
      check("rst_ready", pixel_ready, 0);
      check("rst_ram_ce", ram_ce, 0);
      check("rst_cdf_min", cdf_min, 0);
      check("rst_avail", available, 0);
      rst = 1'b1;
      cyc(2);

      // Reset in the middle of CLEAR
      pulse_start();
      check("clear_first_addr", ram_addr, 0);
      check("clear_first_we", ram_we, 1);
      check("clear_busy", busy, 1);
      cyc(99);
      check("clear_addr_99", ram_addr, 99);
      rst = 1'b0;
      #1;
      check("async_rst_busy", busy, 0);
      check("async_rst_ce", ram_ce, 0);
      check("async_rst_we", ram_we, 0);
      rst = 1'b1;
      cyc(2);
      check("post_rst_idle_busy", busy, 0);
      check("post_rst_ready", pixel_ready, 0);

      // Frame 1: sixteen pixels of value 7 with valid held high
      pixel_valid = 1'b1;
      pixel_data  = 8'd7;
      pulse_start();
      check("f1_ready_in_clear", pixel_ready, 0);
      cyc(255);
      check("f1_clear_last_addr", ram_addr, 255);
      cyc(1);
      check("f1_ready_first", pixel_ready, 1);
      check("f1_read_ce", ram_ce, 1);
      check("f1_read_addr", ram_addr, 7);
      check("f1_read_we", ram_we, 0);
      rdy = 0;
      hg  = 0;
      for (int i = 0; i < 48; i++) begin
         if (pixel_ready) rdy++;
         if (hist_gen) hg++;
         cyc(1);
      end
      check("f1_ready_pulses", rdy, 16);
      check("f1_hist_not_early", hg, 0);
      check("f1_hist_gen", hist_gen, 1);
      check("f1_avail", available, 1);
      check("f1_busy_done", busy, 0);
      check("f1_ready_done", pixel_ready, 0);
      check("f1_bin7", mem[7], 16);
      check("f1_bin0", mem[0], 0);
      check("f1_bin8", mem[8], 0);
      check("f1_bin255", mem[255], 0);
      pixel_valid = 1'b0;

      // CDF of frame 1
      run_cdf();
      check("f1_cdf_min", cdf_min, 16);
      check("f1_cdf_hist_gen", hist_gen, 0);
      check("f1_cdf_avail", available, 1);
      check("f1_cdf_bin6", mem[6], 0);
      check("f1_cdf_bin7", mem[7], 16);
      check("f1_cdf_bin100", mem[100], 16);
      check("f1_cdf_bin255", mem[255], 16);

      // Filter read granted in CDF_DONE
      filter_ce   = 1'b1;
      filter_addr = 8'd200;
      #1;
      check("grant_ce", ram_ce, 1);
      check("grant_addr", ram_addr, 200);
      check("grant_we", ram_we, 0);
      cyc(1);
      check("grant_rdata", ram_rd, 16);
      cdf_start = 1'b1;
      cyc(1);
      cdf_start = 1'b0;
      check("cdf_start_ignored_done", cdf_gen, 1);
      check("cdf_start_ignored_busy", busy, 0);

      // Frame 2: pixels 3,3 then fourteen 200s, filter requesting address 200 throughout
      pix[0] = 8'd3;
      pix[1] = 8'd3;
      for (int i = 2; i < 16; i++) pix[i] = 8'd200;
      pulse_start();
      check("f2_clear_ignores_filter", ram_addr, 0);
      check("f2_clear_avail", available, 0);
      for (int i = 0; i < 16; i++) begin
         wait_ready("f2_ready");
         if (i == 0) check("f2_idle_read_ignores_filter", ram_ce, 0);
         pixel_valid = 1'b1;
         pixel_data  = pix[i];
         #1;
         if (i == 0) check("f2_read_addr", ram_addr, 3);
         cyc(1);
         pixel_valid = 1'b0;
         #1;
         if (i == 0) check("f2_wait_ce", ram_ce, 0);
      end
      wait_hist("f2_hist_gen");
      filter_ce = 1'b0;
      check("f2_bin3", mem[3], 2);
      check("f2_bin200", mem[200], 14);
      check("f2_bin0", mem[0], 0);
      run_cdf();
      check("f2_cdf_min", cdf_min, 2);
      check("f2_cdf_bin2", mem[2], 0);
      check("f2_cdf_bin3", mem[3], 2);
      check("f2_cdf_bin199", mem[199], 2);
      check("f2_cdf_bin200", mem[200], 16);
      check("f2_cdf_bin255", mem[255], 16);

      // Frame 3: cdf_start during ACC is ignored, then the CDF is aborted at bin 100
      pixel_valid = 1'b1;
      pixel_data  = 8'd7;
      pulse_start();
      cyc(256);
      hg = 0;
      for (int i = 0; i < 48; i++) begin
         cdf_start = (i == 10);
         if (hist_gen) hg++;
         cyc(1);
      end
      cdf_start = 1'b0;
      check("f3_hist_not_early", hg, 0);
      check("f3_hist_gen", hist_gen, 1);
      pixel_valid = 1'b0;
      cdf_start = 1'b1;
      cyc(1);
      cdf_start = 1'b0;
      cyc(200);
      check("f3_cdf_read_100", ram_addr, 100);
      check("f3_cdf_read_we", ram_we, 0);
      check("f3_cdf_min_mid", cdf_min, 16);
      pixel_valid = 1'b1;
      pixel_data  = 8'd9;
      pulse_start();
      check("abort_cdf_gen", cdf_gen, 0);
      check("abort_cdf_min", cdf_min, 0);
      check("abort_clear_we", ram_we, 1);
      check("abort_clear_addr", ram_addr, 0);
      cyc(256);
      wait_hist("f4_hist_gen");
      pixel_valid = 1'b0;
      check("f4_cdf_gen", cdf_gen, 0);
      check("f4_bin9", mem[9], 16);
      check("f4_bin7", mem[7], 0);
      check("f4_bin100", mem[100], 0);

      // start and cdf_start together: start wins
      start     = 1'b1;
      cdf_start = 1'b1;
      cyc(1);
      start     = 1'b0;
      cdf_start = 1'b0;
      check("start_wins_we", ram_we, 1);
      check("start_wins_addr", ram_addr, 0);
      check("start_wins_hist", hist_gen, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
